// File: rtl/framebuffer_reader.sv
// Display-side reader: fetches framebuffer lines from SPRAM into ping-pong line buffers
// and serves registered pixels to the scanner. Optional FB_BORDER_EN colours out-of-image pixels.
module framebuffer_reader #(
    parameter int          W            = 160,
    parameter int          H            = 120,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic        line_req,
    input  logic [9:0]  line_y,
    input  logic [9:0]  x_addr,
    input  logic [9:0]  y_addr,
    output logic [11:0] pixel_data,
    output logic        frame_ready,
    output logic        busy,
    output logic        underrun,
    output logic        spram_rd_req,
    input  logic        spram_rd_gnt,
    output logic [14:0] spram_addr,
    input  logic [11:0] spram_rd_data
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] C_END  = CW'(W);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [9:0]    X_LIM  = 10'(W);
    localparam logic [9:0]    Y_LIM  = 10'(H);
    localparam logic [10:0]   L_LIM  = 11'(H);
    localparam logic [14:0]   W15    = 15'(W);

`ifdef FB_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif
    localparam logic [11:0] OOR_PIX = BORDER_EN ? BORDER_COLOR : 12'h000;

    typedef enum logic [1:0] {IDLE, PRELOAD, READY, FETCH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q;
    logic [14:0]     base_q;
    logic            wr_sel_q;
    logic            cap_vld_q;
    logic [XW-1:0]   cap_col_q;
    logic [11:0]     line_buf [2][W];

    logic [10:0]     ly1;
    logic [14:0]     ly1_w;
    logic            line_ok;
    logic            restart;
    logic            enter_fetch;
    logic            accept;
    logic            wr_en;
    logic            last_cap;
    logic            in_img;

    assign ly1         = {1'b0, line_y} + 11'd1;
    assign ly1_w       = 15'(ly1);
    assign line_ok     = (ly1 < L_LIM);
    assign restart     = enable && start && (state_q != PRELOAD);
    assign enter_fetch = enable && (state_q == READY) && !start && line_req && line_ok;
    assign accept      = spram_rd_req && spram_rd_gnt;
    // Return data belonging to an aborted fetch must never land in a buffer.
    assign wr_en       = cap_vld_q && enable && !restart;
    assign last_cap    = wr_en && (cap_col_q == X_LAST);
    assign spram_addr  = base_q + 15'(c_q);
    assign in_img      = (x_addr < X_LIM) && (y_addr < Y_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = PRELOAD;
                PRELOAD: if (last_cap) state_d = READY;
                READY: begin
                    if (start)                    state_d = PRELOAD;
                    else if (line_req && line_ok) state_d = FETCH;
                end
                FETCH: begin
                    if (start)         state_d = PRELOAD;
                    else if (last_cap) state_d = READY;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = 1'b0;
        spram_rd_req = 1'b0;
        case (state_q)
            PRELOAD, FETCH: begin
                busy         = 1'b1;
                spram_rd_req = (c_q < C_END);
            end
            default: ;
        endcase
    end

    // Issue counter, capture pipeline and frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            base_q      <= '0;
            wr_sel_q    <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_col_q   <= '0;
            frame_ready <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= enable && line_req && busy;
            if (!enable) begin
                c_q         <= '0;
                cap_vld_q   <= 1'b0;
                frame_ready <= 1'b0;
            end else if (restart) begin
                c_q         <= '0;
                base_q      <= '0;
                wr_sel_q    <= 1'b0;
                cap_vld_q   <= 1'b0;
                frame_ready <= 1'b0;
            end else if (enter_fetch) begin
                c_q       <= '0;
                base_q    <= ly1_w * W15;
                wr_sel_q  <= ly1[0];
                cap_vld_q <= 1'b0;
            end else begin
                cap_vld_q <= accept;
                cap_col_q <= c_q[XW-1:0];
                if (accept) c_q <= c_q + CW'(1);
                if ((state_q == PRELOAD) && last_cap) frame_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) line_buf[wr_sel_q][cap_col_q] <= spram_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= 12'h000;
        end else if (enable && frame_ready) begin
            pixel_data <= in_img ? line_buf[y_addr[0]][x_addr[XW-1:0]] : OOR_PIX;
        end else begin
            pixel_data <= 12'h000;
        end
    end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Directed bench for framebuffer_reader (W=4, H=3) with a one-cycle-latency SPRAM model
// and queue scoreboards for issued addresses and returned pixels.
module tb_framebuffer_reader;

    localparam int W = 4;
    localparam int H = 3;
`ifdef FB_BORDER_EN
    localparam logic [11:0] OOR = 12'hF0F;
`else
    localparam logic [11:0] OOR = 12'h000;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        line_req;
    logic [9:0]  line_y;
    logic [9:0]  x_addr;
    logic [9:0]  y_addr;
    logic [11:0] pixel_data;
    logic        frame_ready;
    logic        busy;
    logic        underrun;
    logic        spram_rd_req;
    logic        spram_rd_gnt;
    logic [14:0] spram_addr;
    logic [11:0] spram_rd_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [14:0] addr_q[$];
    logic [11:0] px_q[$];

    framebuffer_reader #(.W(W), .H(H), .BORDER_COLOR(12'hF0F)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .line_req(line_req), .line_y(line_y), .x_addr(x_addr), .y_addr(y_addr),
        .pixel_data(pixel_data), .frame_ready(frame_ready), .busy(busy),
        .underrun(underrun), .spram_rd_req(spram_rd_req), .spram_rd_gnt(spram_rd_gnt),
        .spram_addr(spram_addr), .spram_rd_data(spram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM preset: address n holds 12'h100+n; unaccepted cycles return a poison value.
    always @(posedge clk) begin
        if (spram_rd_req && spram_rd_gnt) spram_rd_data <= 12'h100 + 12'(spram_addr);
        else                              spram_rd_data <= 12'hDEA;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_px(input int x, input int y, input logic [11:0] exp, input string tag);
        x_addr = 10'(x);
        y_addr = 10'(y);
        px_q.push_back(exp);
        @(negedge clk);
        check(tag, 32'(pixel_data), 32'(px_q.pop_front()));
    endtask

    task automatic pulse_line_req(input int y);
        line_req = 1'b1;
        line_y   = 10'(y);
        @(negedge clk);
        line_req = 1'b0;
    endtask

    // Follows one fetch from its first issue cycle until busy drops.
    task automatic watch(input int first, input int n, input int stall_at, input int ureq_at,
                         input int exp_busy, input int exp_fr, input string tag);
        int nb, fr_idx, first_iss, last_iss, stall_left, k;
        bit done;
        logic [14:0] ea;
        nb = 0; fr_idx = -1; first_iss = -1; last_iss = -1; stall_left = 0; done = 1'b0;
        for (int i = 0; i < n; i++) addr_q.push_back(15'(first + i));
        for (k = 0; k < 40 && !done; k++) begin
            line_req = (k == ureq_at);
            line_y   = 10'd1;
            if (ureq_at >= 0 && k == ureq_at + 1) check({tag, "_underrun_hi"}, 32'(underrun), 1);
            if (ureq_at >= 0 && k == ureq_at + 2) check({tag, "_underrun_lo"}, 32'(underrun), 0);
            if (stall_left > 0) begin
                spram_rd_gnt = 1'b0;
                stall_left--;
                check({tag, "_stall_req"}, 32'(spram_rd_req), 1);
                check({tag, "_stall_addr"}, 32'(spram_addr), 32'(addr_q[0]));
            end else begin
                spram_rd_gnt = 1'b1;
            end
            if (spram_rd_req && spram_rd_gnt) begin
                ea = (addr_q.size() != 0) ? addr_q.pop_front() : 15'h7FFF;
                check({tag, "_addr"}, 32'(spram_addr), 32'(ea));
                if (first_iss < 0) first_iss = k;
                last_iss = k;
                if (32'(spram_addr) == stall_at) stall_left = 3;
            end
            if (busy) nb++;
            if (frame_ready && fr_idx < 0) fr_idx = k;
            if (addr_q.size() == 0 && !busy) done = 1'b1;
            else @(negedge clk);
        end
        line_req     = 1'b0;
        spram_rd_gnt = 1'b1;
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_cycles"}, nb, exp_busy);
        if (exp_fr >= 0) check({tag, "_ready_cycle"}, fr_idx, exp_fr);
        if (stall_at < 0) check({tag, "_issue_span"}, last_iss - first_iss, n - 1);
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; start = 1'b0; line_req = 1'b0; line_y = '0;
        x_addr = '0; y_addr = '0; spram_rd_gnt = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pixel", 32'(pixel_data), 0);
        check("rst_ready", 32'(frame_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_req", 32'(spram_rd_req), 0);
        check("rst_addr", 32'(spram_addr), 0);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);

        // Preload line 0
        start = 1'b1; @(negedge clk); start = 1'b0;
        watch(0, W, -1, -1, 5, 5, "preload");
        read_px(2, 0, 12'h102, "px_2_0");
        read_px(0, 0, 12'h100, "px_0_0");
        read_px(3, 0, 12'h103, "px_3_0");
        read_px(4, 0, OOR, "px_oor_x");

        // Prefetch line 1
        pulse_line_req(0);
        watch(4, W, -1, -1, 5, -1, "fetch1");
        read_px(3, 1, 12'h107, "px_3_1");
        read_px(0, 0, 12'h100, "px_0_0_kept");
        read_px(1, 1, 12'h105, "px_1_1");

        // Line 2 with a 3-cycle grant stall after address 9
        pulse_line_req(1);
        watch(8, W, 9, -1, 8, -1, "fetch2_stall");
        for (int x = 0; x < W; x++) read_px(x, 2, 12'h108 + 12'(x), "px_line2");
        read_px(0, 3, OOR, "px_oor_y");

        // Request beyond the last line is ignored silently
        pulse_line_req(2);
        check("last_busy", 32'(busy), 0);
        check("last_req", 32'(spram_rd_req), 0);
        @(negedge clk);
        check("last_underrun", 32'(underrun), 0);
        check("last_busy2", 32'(busy), 0);

        // line_req during a fetch is dropped with an underrun pulse
        pulse_line_req(0);
        watch(4, W, -1, 1, 5, -1, "fetch_ur");
        read_px(2, 1, 12'h106, "px_2_1");

        // Drop enable mid-fetch
        x_addr = 10'd0; y_addr = 10'd2;
        pulse_line_req(0);
        check("abort_pre_pixel", 32'(pixel_data), 32'h108);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_req", 32'(spram_rd_req), 0);
        check("abort_ready", 32'(frame_ready), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_pixel", 32'(pixel_data), 0);
        enable = 1'b1;
        read_px(4, 0, 12'h000, "px_oor_not_ready");

        // Asynchronous reset in the middle of a preload
        start = 1'b1; @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(spram_rd_req), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_addr", 32'(spram_addr), 0);
        check("arst_ready", 32'(frame_ready), 0);
        check("arst_pixel", 32'(pixel_data), 0);
        check("arst_underrun", 32'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        watch(0, W, -1, -1, 5, 5, "preload2");
        read_px(1, 0, 12'h101, "px_1_0");

        // start during a fetch aborts it and preloads line 0 again
        pulse_line_req(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ready", 32'(frame_ready), 0);
        check("restart_addr", 32'(spram_addr), 0);
        watch(0, W, -1, -1, 5, 5, "restart");
        read_px(3, 0, 12'h103, "px_3_0_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
